// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - state encoding, winner codes and default match parameters for the pong round controller
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } round_state_t;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b01;
    localparam logic [1:0] WINNER_RIGHT = 2'b10;

    localparam int DEFAULT_WIN_SCORE   = 7;
    localparam int DEFAULT_SCORE_W     = 4;
    localparam int DEFAULT_SERVE_DELAY = 60;
    localparam int DEFAULT_POINT_HOLD  = 30;

    // A zero-length delay would never expire, so it is stretched to one tick.
    function automatic int effective_delay(input int delay);
        return (delay < 1) ? 1 : delay;
    endfunction

endpackage

// File: rtl/round_controller_if.sv
// rtl/round_controller_if.sv - menu, ball datapath and score display signals of the round controller
interface round_controller_if import pong_pkg::*; #(
    parameter int SCORE_W = DEFAULT_SCORE_W
);
    logic               frame_tick;
    logic               run;
    logic               restart;
    logic               miss_left;
    logic               miss_right;
    logic               ball_reset;
    logic               ball_enable;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic [1:0]         winner;
    logic               game_over;

    modport master (
        input  frame_tick, run, restart, miss_left, miss_right,
        output ball_reset, ball_enable, serve_dir, score_left, score_right, winner, game_over
    );

    modport slave (
        output frame_tick, run, restart, miss_left, miss_right,
        input  ball_reset, ball_enable, serve_dir, score_left, score_right, winner, game_over
    );
endinterface

// File: rtl/round_controller_frame_timer.sv
// rtl/round_controller_frame_timer.sv - loadable frame-tick down-counter shared by serve and point hold
module frame_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick_en,
    output logic             done
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick_en && (count != '0)) begin
            count <= count - ONE;
        end
    end

    // Fires on the tick that consumes the last remaining count.
    assign done = tick_en && (count == ONE);

endmodule

// File: rtl/round_controller.sv
// rtl/round_controller.sv - serve/rally/point sequencing, scoring and match end for a pong game
module round_controller import pong_pkg::*; #(
    parameter int WIN_SCORE   = DEFAULT_WIN_SCORE,
    parameter int SCORE_W     = DEFAULT_SCORE_W,
    parameter int SERVE_DELAY = DEFAULT_SERVE_DELAY,
    parameter int POINT_HOLD  = DEFAULT_POINT_HOLD
) (
    input  logic               clock,
    input  logic               reset,
    round_controller_if.master bus
);
    localparam int SERVE_TICKS = effective_delay(SERVE_DELAY);
    localparam int HOLD_TICKS  = effective_delay(POINT_HOLD);
    localparam int MAX_TICKS   = (SERVE_TICKS > HOLD_TICKS) ? SERVE_TICKS : HOLD_TICKS;
    localparam int TIMER_W     = $clog2(MAX_TICKS + 1);

    localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_TICKS);
    localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(HOLD_TICKS);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    round_state_t state;
    round_state_t next_state;

    logic               timer_done;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               match_won;
    logic               entering;

    logic [SCORE_W-1:0] score_left_q,  score_left_d;
    logic [SCORE_W-1:0] score_right_q, score_right_d;
    logic               serve_dir_q,   serve_dir_d;
    logic [1:0]         winner_q,      winner_d;
    logic               ball_reset_q,  ball_reset_d;
    logic               ball_enable_q, ball_enable_d;
    logic               game_over_q,   game_over_d;

    frame_timer #(
        .WIDTH (TIMER_W)
    ) u_frame_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .tick_en    (bus.frame_tick && bus.run),
        .done       (timer_done)
    );

    assign match_won = (score_left_q == WIN) || (score_right_q == WIN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Everything but restart is frozen while the menu has the game paused.
    always_comb begin
        next_state = state;
        if (bus.restart) begin
            next_state = ST_IDLE;
        end else if (bus.run) begin
            unique case (state)
                ST_IDLE:  next_state = ST_SERVE;
                ST_SERVE: if (timer_done) next_state = ST_PLAY;
                ST_PLAY:  if (bus.miss_left || bus.miss_right) next_state = ST_POINT;
                ST_POINT: if (timer_done) next_state = match_won ? ST_OVER : ST_SERVE;
                ST_OVER:  next_state = ST_OVER;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;

        if (next_state == ST_IDLE) begin
            score_left_d  = '0;
            score_right_d = '0;
            serve_dir_d   = 1'b1;
            winner_d      = WINNER_NONE;
        end else if ((state == ST_PLAY) && bus.run) begin
            // A simultaneous double miss is a dead point: nobody scores.
            if (bus.miss_left && !bus.miss_right) begin
                if (score_right_q < WIN) score_right_d = score_right_q + SCORE_ONE;
                serve_dir_d = 1'b0;
            end else if (bus.miss_right && !bus.miss_left) begin
                if (score_left_q < WIN) score_left_d = score_left_q + SCORE_ONE;
                serve_dir_d = 1'b1;
            end
        end else if ((state == ST_POINT) && (next_state == ST_OVER)) begin
            winner_d = (score_left_q == WIN) ? WINNER_LEFT : WINNER_RIGHT;
        end

        entering      = (next_state != state);
        ball_reset_d  = entering && (next_state == ST_SERVE);
        ball_enable_d = (next_state == ST_PLAY) && bus.run;
        game_over_d   = (next_state == ST_OVER);
        timer_load    = entering && ((next_state == ST_SERVE) || (next_state == ST_POINT));
        timer_value   = (next_state == ST_POINT) ? HOLD_LOAD : SERVE_LOAD;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            score_left_q  <= '0;
            score_right_q <= '0;
            serve_dir_q   <= 1'b1;
            winner_q      <= WINNER_NONE;
            ball_reset_q  <= 1'b0;
            ball_enable_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            ball_reset_q  <= ball_reset_d;
            ball_enable_q <= ball_enable_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.score_left  = score_left_q;
    assign bus.score_right = score_right_q;
    assign bus.serve_dir   = serve_dir_q;
    assign bus.winner      = winner_q;
    assign bus.ball_reset  = ball_reset_q;
    assign bus.ball_enable = ball_enable_q;
    assign bus.game_over   = game_over_q;

endmodule
